fp_mul_sequencer: RTL and testbench

Multi-cycle controller that sequences one IEEE-754 single-precision multiply through the shared 24×24 mantissa multiplier, using a valid/ready handshake on both sides. It covers operand unpack, special-case decode, registered mantissa product, normalisation, rounding and pack. It sits in the FP ALU between the operation dispatcher and the result writeback mux, and replaces the purely combinational multiply path.

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_mul_sequencer_if.sv | 26 ++
 rtl/binary_multiplier.sv | 10 +
 rtl/fp_mul_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fp_mul_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 multiply sequencer: FSM state encoding, FP32 field widths,
// exponent bias, the canonical quiet NaN, flag bit positions and operand-classification helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StNorm,
    StRnd,
    StDone
  } state_e;

  localparam int unsigned ExpW  = 8;
  localparam int unsigned FracW = 23;
  localparam int unsigned MantW = FracW + 1;
  localparam int unsigned ProdW = 2 * MantW;

  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Positions within out_flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;  // true zero or subnormal (subnormals are flushed)
  } fp_class_t;

  function automatic fp_class_t classify(logic [31:0] x);
    fp_class_t c;
    c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    c.snan = c.nan && !x[22];
    c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    c.zero = (x[30:23] == 8'h00);
    return c;
  endfunction

  // Mantissa with hidden bit; subnormals and zeros collapse to 0.
  function automatic logic [MantW-1:0] mantissa(logic [31:0] x);
    return (x[30:23] == 8'h00) ? '0 : {1'b1, x[22:0]};
  endfunction

endpackage

// File: rtl/fp_mul_sequencer_if.sv
// Handshake bundle between the operation dispatcher (master), the FP multiply sequencer (slave)
// and the writeback consumer.
//   in_valid/in_ready/in_a/in_b    : operand channel
//   out_valid/out_ready/out_data/out_flags : result channel, flags = {invalid,ovf,unf,inexact}
//   busy                           : sequencer is not idle
interface fp_mul_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flags, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flags, busy
  );
endinterface

// File: rtl/binary_multiplier.sv
// Shared unsigned 24x24 mantissa multiplier.
//   a, b : 24-bit unsigned operands
//   p    : 48-bit product
module binary_multiplier (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  assign p = {24'b0, a} * {24'b0, b};
endmodule

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle IEEE-754 single-precision multiply: IDLE latches operands, MUL registers the
// mantissa product, NORM aligns it, RND rounds/packs, DONE holds the result until accepted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, discards any in-flight operation
//   bus   : fp_mul_sequencer_if.slave (operand/result handshakes, busy)
// Build option: define FPMUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_sequencer
  import fp_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  fp_mul_sequencer_if.slave bus
);

  localparam logic signed [9:0] Bias = 10'(EXP_BIAS);

  state_e state_q, state_d;

  logic              sign_q;
  logic [ExpW-1:0]   ea_q, eb_q;
  logic [MantW-1:0]  ma_q, mb_q;
  fp_class_t         cls_a_q, cls_b_q;
  logic [ProdW-1:0]  prod_q;
  logic signed [9:0] exp_q;
  logic [FracW-1:0]  frac_q;
  logic              guard_q, sticky_q;
  logic [31:0]       out_data_q;
  logic [3:0]        out_flags_q;

  logic [ProdW-1:0]  prod;
  logic              round_up;
  logic [FracW:0]    frac_rnd;
  logic signed [9:0] exp_fin;
  logic              inexact;
  logic [31:0]       res_data;
  logic [3:0]        res_flags;

  binary_multiplier u_mult (
    .a (ma_q),
    .b (mb_q),
    .p (prod)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StMul;
      StMul:   state_d = StNorm;
      StNorm:  state_d = StRnd;
      StRnd:   state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // in_ready is gated by rst_n so it reads low throughout reset.
  assign bus.in_ready  = rst_n && (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  // Rounding and packing
  always_comb begin
`ifdef FPMUL_RNE_EN
    round_up = guard_q && (sticky_q || frac_q[0]);
`else
    round_up = 1'b0;
`endif
    frac_rnd = {1'b0, frac_q} + {{FracW{1'b0}}, round_up};
    // A carry out of the fraction leaves frac_rnd[22:0] at zero and bumps the exponent.
    exp_fin  = exp_q + $signed({9'b0, frac_rnd[FracW]});
    inexact  = guard_q || sticky_q;

    res_data  = '0;
    res_flags = '0;
    if (cls_a_q.nan || cls_b_q.nan) begin
      res_data               = QNAN;
      res_flags[FlagInvalid] = cls_a_q.snan || cls_b_q.snan;
    end else if ((cls_a_q.inf && cls_b_q.zero) || (cls_a_q.zero && cls_b_q.inf)) begin
      res_data               = QNAN;
      res_flags[FlagInvalid] = 1'b1;
    end else if (cls_a_q.inf || cls_b_q.inf) begin
      res_data = {sign_q, 8'hFF, 23'b0};
    end else if (cls_a_q.zero || cls_b_q.zero) begin
      res_data = {sign_q, 31'b0};
    end else if (exp_fin >= 10'sd255) begin
      res_data                = {sign_q, 8'hFF, 23'b0};
      res_flags[FlagOverflow] = 1'b1;
      res_flags[FlagInexact]  = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      res_data                 = {sign_q, 31'b0};
      res_flags[FlagUnderflow] = 1'b1;
      res_flags[FlagInexact]   = 1'b1;
    end else begin
      res_data               = {sign_q, exp_fin[7:0], frac_rnd[FracW-1:0]};
      res_flags[FlagInexact] = inexact;
    end
  end

  // Datapath registers, one stage per state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cls_a_q     <= '0;
      cls_b_q     <= '0;
      prod_q      <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            sign_q  <= bus.in_a[31] ^ bus.in_b[31];
            ea_q    <= bus.in_a[30:23];
            eb_q    <= bus.in_b[30:23];
            ma_q    <= mantissa(bus.in_a);
            mb_q    <= mantissa(bus.in_b);
            cls_a_q <= classify(bus.in_a);
            cls_b_q <= classify(bus.in_b);
          end
        end
        StMul: begin
          prod_q <= prod;
          exp_q  <= $signed({2'b0, ea_q}) + $signed({2'b0, eb_q}) - Bias;
        end
        StNorm: begin
          if (prod_q[47]) begin
            frac_q   <= prod_q[46:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            frac_q   <= prod_q[45:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
        end
        StRnd: begin
          out_data_q  <= res_data;
          out_flags_q <= res_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Self-checking bench for fp_mul_sequencer: directed vector table, randomized operands against
// an arithmetic reference model, and hand-written backpressure / issue-interval / reset sequences.
module tb_fp_mul_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_sequencer_if bus ();

  fp_mul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
    end
  endtask

  // Reference: exact integer product, normalise by magnitude, round by comparing the discarded
  // remainder against half an ulp.
  function automatic res_t ref_mul(logic [31:0] a, logic [31:0] b);
    res_t r;
    logic s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic an, bn, asn, bsn, ai, bi, az, bz, inexact;
    longint unsigned ma, mb, p, keep, rem, half;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = a[22:0];
    fb  = b[22:0];
    an  = (ea == 255) && (fa != 0);
    bn  = (eb == 255) && (fb != 0);
    asn = an && !fa[22];
    bsn = bn && !fb[22];
    ai  = (ea == 255) && (fa == 0);
    bi  = (eb == 255) && (fb == 0);
    az  = (ea == 0);
    bz  = (eb == 0);
    r.flags = 4'b0;
    if (an || bn) begin
      r.data = 32'h7FC0_0000;
      r.flags[3] = asn || bsn;
    end else if ((ai && bz) || (az && bi)) begin
      r.data = 32'h7FC0_0000;
      r.flags[3] = 1'b1;
    end else if (ai || bi) begin
      r.data = {s, 8'hFF, 23'b0};
    end else if (az || bz) begin
      r.data = {s, 31'b0};
    end else begin
      ma   = {41'b0, 1'b1, fa};
      mb   = {41'b0, 1'b1, fb};
      p    = ma * mb;
      e    = ea + eb - 127;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      keep = p >> sh;
      rem  = p - (keep << sh);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 0);
`ifdef FPMUL_RNE_EN
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin
        keep = keep >> 1;
        e++;
      end
`endif
      if (e >= 255) begin
        r.data  = {s, 8'hFF, 23'b0};
        r.flags = 4'b0101;
      end else if (e <= 0) begin
        r.data  = {s, 31'b0};
        r.flags = 4'b0011;
      end else begin
        r.data  = {s, 8'(e), keep[22:0]};
        r.flags = {3'b0, inexact};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    logic [7:0]  e;
    int          cls;
    x   = $urandom;
    cls = int'($urandom_range(0, 9));
    case (cls)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; x[22:0] = '0; end
      2:       begin e = 8'hFF; x[0] = 1'b1; end
      3:       e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(64, 190));
    endcase
    x[30:23] = e;
    return x;
  endfunction

  // Returns at 1ns after the edge that took the operands, or after the budget runs out.
  task automatic wait_accept(output bit acc);
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Counts edges from the current point until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       output res_t got);
    bit acc;
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    wait_accept(acc);
    bus.in_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    // The result appears three edges after the accepting edge.
    wait_valid(n);
    check("latency", 32'(n), 32'd3);
    got.data  = bus.out_data;
    got.flags = bus.out_flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_data", bus.out_data, got.data);
      check("hold_flags", 32'(bus.out_flags), 32'(got.flags));
      check("hold_valid_ready", {30'b0, bus.out_valid, bus.in_ready}, 32'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("idle_after_handshake", {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t got, want;
    bit   acc;
    int   n, vcount, stray;
    logic [31:0] a2, b2;

    vecs.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0});
    vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'h0});
`ifdef FPMUL_RNE_EN
    vecs.push_back('{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 4'h1});
`else
    vecs.push_back('{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, 4'h1});
`endif
    vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h8});
    vecs.push_back('{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'h5});
    vecs.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'h3});
    vecs.push_back('{32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'h8});
    vecs.push_back('{32'h7FC0_0000, 32'h4000_0000, 32'h7FC0_0000, 4'h0});
    vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0});
    vecs.push_back('{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'h0});
    vecs.push_back('{32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 4'h0});
    vecs.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 4'h0});

    // Reset
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    check("reset_out_flags", 32'(bus.out_flags), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    vcount = vecs.size();
    for (int i = 0; i < vcount; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, got);
      check($sformatf("vec%0d_data", i), got.data, vecs[i].data);
      check($sformatf("vec%0d_flags", i), 32'(got.flags), 32'(vecs[i].flags));
    end

    // Backpressure: a second request waits until the held result is taken.
    bus.in_a     = 32'h4000_0000;
    bus.in_b     = 32'h4040_0000;
    bus.in_valid = 1'b1;
    wait_accept(acc);
    check("bp_accept", 32'(acc), 32'd1);
    a2 = 32'h3FC0_0000;
    b2 = 32'hC000_0000;
    bus.in_a = a2;
    bus.in_b = b2;
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", bus.out_data, 32'h40C0_0000);
      check("bp_flags", 32'(bus.out_flags), 32'd0);
      check("bp_valid_ready_busy", {29'b0, bus.out_valid, bus.in_ready, bus.busy}, 32'b101);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ready", {30'b0, bus.in_ready, bus.busy}, 32'b10);
    do_op(a2, b2, 1, got);
    want = ref_mul(a2, b2);
    check("bp_second_data", got.data, want.data);
    check("bp_second_flags", 32'(got.flags), 32'(want.flags));

    // Back-to-back with out_ready held high: one-cycle out_valid, five-edge issue interval.
    bus.in_a      = 32'h3FC0_0001;
    bus.in_b      = 32'h4000_0000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    wait_accept(acc);
    check("b2b_accept", 32'(acc), 32'd1);
    n     = 0;
    stray = 0;
    acc   = 1'b0;
    while (!acc && n < 20) begin
      acc = bus.in_ready;
      if (bus.out_valid) begin
        stray++;
        check("b2b_data", bus.out_data, ref_mul(32'h3FC0_0001, 32'h4000_0000).data);
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_interval", 32'(n), 32'd5);
    check("b2b_valid_cycles", 32'(stray), 32'd1);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("b2b_second_latency", 32'(n), 32'd3);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("b2b_second_one_cycle", 32'(bus.out_valid), 32'd0);

    // Reset during NORM
    bus.in_a     = 32'h4000_0000;
    bus.in_b     = 32'h4040_0000;
    bus.in_valid = 1'b1;
    wait_accept(acc);
    bus.in_valid = 1'b0;
    check("rst_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) stray++;
    end
    check("rst_no_stale_result", 32'(stray), 32'd0);

    // Randomized against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      ra   = rand_op();
      rb   = rand_op();
      want = ref_mul(ra, rb);
      do_op(ra, rb, int'($urandom_range(0, 3)), got);
      if (got.data !== want.data || got.flags !== want.flags)
        $display("  operands a=0x%08h b=0x%08h", ra, rb);
      check($sformatf("rand%0d_data", i), got.data, want.data);
      check($sformatf("rand%0d_flags", i), 32'(got.flags), 32'(want.flags));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
